// File: rtl/component_tap_mac.sv
// Sequential multiply-accumulate over a snapshot of the delay-line tap vector.
// One tap per cycle against a programmable signed coefficient bank.
module component_tap_mac #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAPS  = 5,
    localparam int unsigned ACC_W = 2 * WIDTH + $clog2(TAPS),
    localparam int unsigned IDX_W = $clog2(TAPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [0:TAPS-1][WIDTH-1:0]   taps_in,
    input  logic                         start,
    input  logic                         coef_we,
    input  logic [IDX_W-1:0]             coef_addr,
    input  logic [WIDTH-1:0]             coef_data,
    output logic                         busy,
    output logic                         done,
    output logic signed [ACC_W-1:0]      result,
    output logic                         coef_err
);

    typedef enum logic [0:0] {StIdle, StAccum} state_t;

    state_t                    r_state;
    state_t                    w_state_d;
    logic signed [WIDTH-1:0]   r_snap [TAPS];
    logic signed [WIDTH-1:0]   r_coef [TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   w_acc_d;
    logic signed [ACC_W-1:0]   r_result;
    logic signed [ACC_W-1:0]   w_result_d;
    logic [IDX_W-1:0]          r_idx;
    logic [IDX_W-1:0]          w_idx_d;
    logic                      r_done;
    logic                      w_done_d;
    logic                      r_err;
    logic                      w_err_d;
    logic                      w_snap_ld;
    logic                      w_coef_wr;
    logic                      w_addr_ok;
    logic                      w_last;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;

    assign w_prod     = r_snap[r_idx] * r_coef[r_idx];
    assign w_prod_ext = {{(ACC_W - 2 * WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
    assign w_last     = (32'(r_idx) == TAPS - 1);
    assign w_addr_ok  = (32'(coef_addr) < TAPS);

    // Writes only land while idle; a write that coincides with start still lands
    // because index 0 is not read until the following edge.
    assign w_coef_wr  = coef_we && (r_state == StIdle) && w_addr_ok;
    assign w_err_d    = coef_we && ((r_state == StAccum) || !w_addr_ok);

    always_comb begin
        w_state_d  = r_state;
        w_idx_d    = r_idx;
        w_acc_d    = r_acc;
        w_result_d = r_result;
        w_done_d   = 1'b0;
        w_snap_ld  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StAccum;
                    w_snap_ld = 1'b1;
                    w_acc_d   = '0;
                    w_idx_d   = '0;
                end
            end
            StAccum: begin
                w_acc_d = r_acc + w_prod_ext;
                w_idx_d = r_idx + 1'b1;
                if (w_last) begin
                    w_state_d  = StIdle;
                    w_done_d   = 1'b1;
                    w_result_d = r_acc + w_prod_ext;
                    w_idx_d    = '0;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_acc    <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_snap[i] <= '0;
                r_coef[i] <= '0;
            end
        end else begin
            r_state  <= w_state_d;
            r_acc    <= w_acc_d;
            r_result <= w_result_d;
            r_idx    <= w_idx_d;
            r_done   <= w_done_d;
            r_err    <= w_err_d;
            if (w_snap_ld) begin
                for (int i = 0; i < TAPS; i++) begin
                    r_snap[i] <= taps_in[i];
                end
            end
            if (w_coef_wr) begin
                r_coef[coef_addr] <= coef_data;
            end
        end
    end

    assign busy     = (r_state == StAccum);
    assign done     = r_done;
    assign result   = r_result;
    assign coef_err = r_err;

endmodule

// File: tb/tb_component_tap_mac.sv
// Self-checking bench for component_tap_mac: vector table plus hand-written
// corner sequences, with a result scoreboard popped on every done pulse.
module tb_component_tap_mac;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned TAPS  = 5;
    localparam int unsigned ACC_W = 2 * WIDTH + $clog2(TAPS);

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [0:TAPS-1][WIDTH-1:0] taps_in = '0;
    logic                       start = 1'b0;
    logic                       coef_we = 1'b0;
    logic [2:0]                 coef_addr = '0;
    logic [WIDTH-1:0]           coef_data = '0;
    logic                       busy;
    logic                       done;
    logic signed [ACC_W-1:0]    result;
    logic                       coef_err;

    component_tap_mac #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .taps_in   (taps_in),
        .start     (start),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .coef_err  (coef_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:TAPS-1][WIDTH-1:0] coef;
        logic [0:TAPS-1][WIDTH-1:0] taps;
        int                         exp;
    } vec_t;

    vec_t                       vecs [6];
    logic [0:TAPS-1][WIDTH-1:0] coef_m;
    int                         sb [$];
    int                         n_checks = 0;
    int                         n_pass   = 0;
    int                         n_done   = 0;
    int                         n_start  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int model(input logic [0:TAPS-1][WIDTH-1:0] c,
                                 input logic [0:TAPS-1][WIDTH-1:0] t);
        int s = 0;
        for (int i = 0; i < TAPS; i++) begin
            s += int'($signed(c[i])) * int'($signed(t[i]));
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("result", result, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input logic [WIDTH-1:0] data);
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = data;
        step();
        coef_we   = 1'b0;
        if (addr < TAPS) coef_m[addr] = data;
    endtask

    // mode 0: plain run; 1: zero taps and re-start mid-run; 2: coefficient write while busy
    task automatic run(input logic [0:TAPS-1][WIDTH-1:0] t, input int exp, input int mode);
        taps_in = t;
        start   = 1'b1;
        sb.push_back(exp);
        n_start++;
        step();
        start   = 1'b0;
        coef_we = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            check("busy_run", busy, 1);
            check("done_early", done, 0);
            if (mode == 1 && k == 0) begin
                taps_in = '0;
                start   = 1'b1;
            end
            if (mode == 1 && k == 1) start = 1'b0;
            if (mode == 2 && k == 0) begin
                coef_we   = 1'b1;
                coef_addr = 3'd2;
                coef_data = 8'd7;
            end
            if (mode == 2 && k == 1) begin
                check("coef_err_busy", coef_err, 1);
                coef_we = 1'b0;
            end
            if (mode == 2 && k == 2) check("coef_err_clear", coef_err, 0);
            step();
        end
        check("busy_end", busy, 0);
        check("done_pulse", done, 1);
        step();
        check("done_clear", done, 0);
    endtask

    initial begin
        vecs[0] = '{coef: {8'd1, 8'd1, 8'd1, 8'd1, 8'd1},
                    taps: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, exp: 15};
        vecs[1] = '{coef: {5{8'h80}}, taps: {5{8'h80}}, exp: 81920};
        vecs[2] = '{coef: {5{8'h80}}, taps: {5{8'h7f}}, exp: -81280};
        vecs[3] = '{coef: {8'd1, -8'sd1, 8'd2, -8'sd2, 8'd3},
                    taps: {8'd10, 8'd20, 8'd30, 8'd40, 8'd50}, exp: 120};
        vecs[4] = '{coef: {8'd127, 8'd0, 8'd0, 8'd0, 8'h80},
                    taps: {8'd127, 8'd5, 8'd5, 8'd5, 8'h80}, exp: 32513};
        vecs[5] = '{coef: {-8'sd3, 8'd4, -8'sd5, 8'd6, -8'sd7},
                    taps: {8'd7, -8'sd6, 8'd5, -8'sd4, 8'd3}, exp: -115};
        coef_m = '0;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", coef_err, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < TAPS; i++) write_coef(i, vecs[v].coef[i]);
            run(vecs[v].taps, vecs[v].exp, 0);
        end

        for (int r = 0; r < 4; r++) begin
            logic [0:TAPS-1][WIDTH-1:0] t;
            for (int i = 0; i < TAPS; i++) begin
                write_coef(i, 8'($urandom));
                t[i] = 8'($urandom);
            end
            run(t, model(coef_m, t), 0);
        end

        // Snapshot isolation and ignored mid-run start.
        for (int i = 0; i < TAPS; i++) write_coef(i, vecs[3].coef[i]);
        run(vecs[3].taps, 120, 1);
        check("no_restart_busy", busy, 0);

        // Write rejected while busy, coef[2] stays 2: sum of coefs = 3.
        run({5{8'd1}}, 3, 2);
        run({5{8'd1}}, 3, 0);
        write_coef(5, 8'd9);
        check("coef_err_addr", coef_err, 1);
        step();
        check("coef_err_addr_clear", coef_err, 0);

        // Write coinciding with start: new coef[0]=3 is used.
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 8'd3;
        run({8'd1, 8'd0, 8'd0, 8'd0, 8'd0}, 3, 0);
        check("coef_err_start_write", coef_err, 0);

        // Continuous start: one idle cycle between runs.
        taps_in = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(3);
            n_start++;
        end
        start = 1'b1;
        for (int c = 0; c < 18; c++) begin
            step();
            check("bb_done", done, (c % 6 == 5) ? 1 : 0);
            check("bb_busy", busy, (c % 6 == 5) ? 0 : 1);
            if (c == 17) start = 1'b0;
        end
        step();
        check("bb_idle", busy, 0);

        // Reset two edges into a run.
        taps_in = {5{8'd1}};
        start   = 1'b1;
        step();
        start   = 1'b0;
        step();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        step();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check("abort_no_done", done, 0);
        end
        run({5{8'd1}}, 0, 0);

        repeat (3) step();
        check("sb_empty", sb.size(), 0);
        check("done_count", n_done, n_start);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
